// File: rtl/key_reset_conditioner.sv
// key_reset_conditioner
//
// Front end between the DE1-SoC pushbuttons and the Nios/HPS system, all in
// the clk_clk domain:
//   - 2-flop synchronizer and per-key debouncer on the active-low KEY inputs,
//     with one-cycle press/release events
//   - stretched active-high system reset (KEY[3] and reset_reset)
//   - minimum-width active-low WiFi module reset (KEY[0] or software PIO)
//
// Ports:
//   clk_clk          in   system clock (50 MHz)
//   reset_reset      in   asynchronous active-high reset
//   key_n            in   raw pushbuttons, active-low, asynchronous
//   wifi_reset_n_in  in   software WiFi reset request, active-low, clk_clk domain
//   key_level        out  debounced key state, 1 = pressed
//   key_press        out  one-cycle pulse when a press is accepted
//   key_release      out  one-cycle pulse when a release is accepted
//   key_long         out  one-cycle long-press pulse (0 unless KEY_LONG_PRESS_EN)
//   sys_reset        out  stretched system reset, active-high, registered
//   wifi_rst_n       out  WiFi module reset, active-low, registered
//
// Build option: define KEY_LONG_PRESS_EN to build the per-key long-press
// counters (LONG_PRESS_CYCLES must then be >= 2). Without it key_long is 0.
//
// Reset FSM:
//   state   | meaning
//   STRETCH | sys_reset held while the hold counter runs to RESET_HOLD_CYCLES-1
//   RUN     | system running, sys_reset released
//   HELD    | KEY[3] pressed, sys_reset held until the key is released

module key_reset_conditioner #(
    parameter int NUM_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES   = 1000000,
    parameter int RESET_HOLD_CYCLES = 16,
    parameter int WIFI_RST_CYCLES   = 500000,
    parameter int LONG_PRESS_CYCLES = 50000000
) (
    input  logic                clk_clk,
    input  logic                reset_reset,
    input  logic [NUM_KEYS-1:0] key_n,
    input  logic                wifi_reset_n_in,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long,
    output logic                sys_reset,
    output logic                wifi_rst_n
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int HOLD_W = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam int WIFI_W = $clog2(WIFI_RST_CYCLES + 1);
    localparam logic [WIFI_W-1:0] WIFI_LOAD = WIFI_W'(WIFI_RST_CYCLES);

    typedef enum logic [1:0] {STRETCH, RUN, HELD} rst_state_t;

    logic [NUM_KEYS-1:0] sync_q1;
    logic [NUM_KEYS-1:0] sync_q2;
    logic [NUM_KEYS-1:0] stable;        // debounced raw polarity, 1 = released
    logic [NUM_KEYS-1:0] flip;
    logic [NUM_KEYS-1:0] stable_nxt;
    logic [DB_W-1:0]     db_cnt [NUM_KEYS];

    rst_state_t          state;
    rst_state_t          state_nxt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_cnt_nxt;
    logic                key3_down;

    logic                wifi_req;
    logic [WIFI_W-1:0]   wifi_cnt;

    // ---------------------------------------------------------------- sync
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync_q1 <= '1;
            sync_q2 <= '1;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
        end
    end

    // ------------------------------------------------------------ debounce
    always_comb begin
        flip = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            flip[i] = (sync_q2[i] != stable[i]) && (db_cnt[i] == DB_LAST);
        end
    end

    assign stable_nxt = stable ^ flip;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            stable      <= '1;
            key_press   <= '0;
            key_release <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            stable      <= stable_nxt;
            key_press   <= flip & stable;
            key_release <= flip & ~stable;
            for (int i = 0; i < NUM_KEYS; i++) begin
                if ((sync_q2[i] == stable[i]) || flip[i]) begin
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    assign key_level = ~stable;

    // ----------------------------------------------------------- reset FSM
    // The FSM reacts to KEY[3] on the same edge the debouncer accepts it, so
    // the registered sys_reset (one cycle behind the state) rises the edge
    // after the key_press[3] cycle.
    assign key3_down = ~stable_nxt[3];

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            STRETCH: begin
                if (key3_down) begin
                    state_nxt    = HELD;
                    hold_cnt_nxt = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nxt    = RUN;
                    hold_cnt_nxt = '0;
                end else begin
                    hold_cnt_nxt = hold_cnt + HOLD_W'(1);
                end
            end
            RUN: begin
                if (flip[3] && stable[3]) begin
                    state_nxt = HELD;
                end
            end
            HELD: begin
                if (!key3_down) begin
                    state_nxt    = STRETCH;
                    hold_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt    = STRETCH;
                hold_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state     <= STRETCH;
            hold_cnt  <= '0;
            sys_reset <= 1'b1;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_cnt_nxt;
            sys_reset <= (state != RUN);
        end
    end

    // ---------------------------------------------------------- WiFi reset
    assign wifi_req = key_level[0] | ~wifi_reset_n_in;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            wifi_cnt   <= WIFI_LOAD;
            wifi_rst_n <= 1'b0;
        end else begin
            if (wifi_req) begin
                wifi_cnt <= WIFI_LOAD;
            end else if (wifi_cnt != '0) begin
                wifi_cnt <= wifi_cnt - WIFI_W'(1);
            end
            wifi_rst_n <= (wifi_cnt == '0) && !wifi_req;
        end
    end

    // ---------------------------------------------------------- long press
`ifdef KEY_LONG_PRESS_EN
    localparam int LP_W = $clog2(LONG_PRESS_CYCLES) + 1;
    localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_CYCLES);
    // The pulse is registered on the edge the counter steps to LONG_PRESS_CYCLES-1.
    localparam logic [LP_W-1:0] LP_FIRE = LP_W'(LONG_PRESS_CYCLES - 2);

    logic [LP_W-1:0] lp_cnt [NUM_KEYS];

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            key_long <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                lp_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                key_long[i] <= key_level[i] && (lp_cnt[i] == LP_FIRE);
                if (!key_level[i]) begin
                    lp_cnt[i] <= '0;
                end else if (lp_cnt[i] != LP_MAX) begin
                    lp_cnt[i] <= lp_cnt[i] + LP_W'(1);
                end
            end
        end
    end
`else
    assign key_long = '0;
`endif

endmodule

// File: tb/tb_key_reset_conditioner.sv
module tb_key_reset_conditioner;
    localparam int NK = 4;
    localparam int DC = 8;
    localparam int RH = 4;
    localparam int WC = 6;
    localparam int LP = 20;

    logic          clk_clk = 1'b0;
    logic          reset_reset;
    logic [NK-1:0] key_n;
    logic          wifi_reset_n_in;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_release;
    logic [NK-1:0] key_long;
    logic          sys_reset;
    logic          wifi_rst_n;

    always #5 clk_clk = ~clk_clk;

    key_reset_conditioner #(
        .NUM_KEYS(NK),
        .DEBOUNCE_CYCLES(DC),
        .RESET_HOLD_CYCLES(RH),
        .WIFI_RST_CYCLES(WC),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk_clk(clk_clk),
        .reset_reset(reset_reset),
        .key_n(key_n),
        .wifi_reset_n_in(wifi_reset_n_in),
        .key_level(key_level),
        .key_press(key_press),
        .key_release(key_release),
        .key_long(key_long),
        .sys_reset(sys_reset),
        .wifi_rst_n(wifi_rst_n)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: edges counted from reset release.
    //  - a key level flips on the DC-th consecutive edge on which the
    //    2-edge-delayed raw sample disagrees with it
    //  - sys_reset is low only once H+2 edges have passed since KEY[3] was
    //    last seen pressed (reset release counts as "pressed at edge -1")
    //  - wifi_rst_n is high once WC+1 edges have passed since the last edge
    //    that sampled a request (reset release counts as edge 0)
    int            ed;
    int            last_key3;
    int            last_req;
    int            diff_run [NK];
    int            held_run [NK];
    logic [NK-1:0] m_lvl, m_press, m_rel, m_long;
    logic [NK-1:0] seen_q [$];
    logic [NK-1:0] acc_press;
    int            hold_left [NK];
    int            long_cnt, long_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ed        = 0;
        last_key3 = -1;
        last_req  = 0;
        m_lvl     = '0;
        m_press   = '0;
        m_rel     = '0;
        m_long    = '0;
        for (int i = 0; i < NK; i++) begin
            diff_run[i] = 0;
            held_run[i] = 0;
        end
        seen_q.delete();
        seen_q.push_back('1);
        seen_q.push_back('1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_level"},   key_level,   0);
        chk({tag, "_press"},   key_press,   0);
        chk({tag, "_release"}, key_release, 0);
        chk({tag, "_long"},    key_long,    0);
        chk({tag, "_sys"},     sys_reset,   1);
        chk({tag, "_wifi"},    wifi_rst_n,  0);
    endtask

    task automatic step(input int n = 1);
        logic [NK-1:0] seen, lvl_prev;
        logic          exp_sys, exp_wifi;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_clk);
            ed++;
            lvl_prev = m_lvl;
            if (lvl_prev[0] || !wifi_reset_n_in) last_req = ed;
            exp_sys  = !((ed - 1) >= (last_key3 + RH + 1));
            exp_wifi = (ed >= last_req + WC + 1);
            seen_q.push_back(key_n);
            seen = seen_q.pop_front();
            m_press = '0;
            m_rel   = '0;
            m_long  = '0;
            for (int i = 0; i < NK; i++) begin
`ifdef KEY_LONG_PRESS_EN
                m_long[i] = lvl_prev[i] && (held_run[i] == LP - 1);
`endif
                if (seen[i] == lvl_prev[i]) begin
                    diff_run[i]++;
                    if (diff_run[i] == DC) begin
                        m_lvl[i]    = ~m_lvl[i];
                        diff_run[i] = 0;
                        m_press[i]  = m_lvl[i];
                        m_rel[i]    = ~m_lvl[i];
                    end
                end else begin
                    diff_run[i] = 0;
                end
                held_run[i] = m_lvl[i] ? held_run[i] + 1 : 0;
            end
            if (m_lvl[3]) last_key3 = ed;
            @(negedge clk_clk);
            acc_press |= key_press;
            chk("m_level",   key_level,   m_lvl);
            chk("m_press",   key_press,   m_press);
            chk("m_release", key_release, m_rel);
            chk("m_long",    key_long,    m_long);
            chk("m_sys",     sys_reset,   exp_sys);
            chk("m_wifi",    wifi_rst_n,  exp_wifi);
        end
    endtask

    initial begin
        reset_reset     = 1'b1;
        key_n           = '1;
        wifi_reset_n_in = 1'b1;
        acc_press       = '0;
        model_reset();
        repeat (3) @(negedge clk_clk);
        chk_reset_vals("por");

        // reset release
        reset_reset = 1'b0;
        step(4);  chk("sys_hold_e4", sys_reset, 1);
        step(1);  chk("sys_fall_e5", sys_reset, 0);
        step(1);  chk("wifi_low_e6", wifi_rst_n, 0);
        step(1);  chk("wifi_rise_e7", wifi_rst_n, 1);
        chk("no_events_after_por", acc_press, 0);

        // clean press / release of KEY[1]
        key_n[1] = 1'b0;
        step(9);  chk("press1_before", key_press, 0);
        step(1);  chk("press1_e10", key_press, 4'b0010);
                  chk("level1_set", key_level, 4'b0010);
        step(1);  chk("press1_single", key_press, 0);
        step(5);
        key_n[1] = 1'b1;
        step(9);  chk("rel1_before", key_release, 0);
        step(1);  chk("rel1_e10", key_release, 4'b0010);
        step(1);  chk("rel1_single", key_release, 0);
                  chk("level1_clr", key_level, 0);

        // glitch rejection on KEY[2]
        acc_press = '0;
        repeat (5) begin
            key_n[2] = 1'b0; step(7);
            key_n[2] = 1'b1; step(1);
        end
        step(10);
        chk("glitch_no_press", acc_press[2], 0);
        chk("glitch_level", key_level[2], 0);

        // system reset key
        key_n[3] = 1'b0;
        step(9);  chk("sys_run_before_press", sys_reset, 0);
        step(1);  chk("press3_e10", key_press, 4'b1000);
                  chk("sys_low_in_press_cycle", sys_reset, 0);
        step(1);  chk("sys_rise_after_press", sys_reset, 1);
        step(5);
        key_n[3] = 1'b1;
        step(10); chk("rel3_e10", key_release, 4'b1000);
                  chk("sys_held_at_release", sys_reset, 1);
        step(4);  chk("sys_stretch_r4", sys_reset, 1);
        step(1);  chk("sys_fall_r5", sys_reset, 0);

        // WiFi reset from software
        wifi_reset_n_in = 1'b0; step(1);
        wifi_reset_n_in = 1'b1; chk("wifi_req_low", wifi_rst_n, 0);
        step(6);  chk("wifi_low_e7", wifi_rst_n, 0);
        step(1);  chk("wifi_rise_e8", wifi_rst_n, 1);
        wifi_reset_n_in = 1'b0; step(1);
        wifi_reset_n_in = 1'b1; step(3);
        wifi_reset_n_in = 1'b0; step(1);
        wifi_reset_n_in = 1'b1; chk("wifi_rereq_low", wifi_rst_n, 0);
        step(6);  chk("wifi_rereq_e7", wifi_rst_n, 0);
        step(1);  chk("wifi_rereq_e8", wifi_rst_n, 1);

        // long press on KEY[1]
        key_n[1] = 1'b0;
        step(10); chk("press1_long", key_press, 4'b0010);
        long_cnt = 0;
        long_at  = -1;
        for (int k = 1; k <= 40; k++) begin
            step(1);
            if (key_long[1]) begin
                long_cnt++;
                long_at = k;
            end
        end
`ifdef KEY_LONG_PRESS_EN
        chk("long_count", long_cnt, 1);
        chk("long_edge", long_at, 19);
`else
        chk("long_count", long_cnt, 0);
`endif
        key_n[1] = 1'b1;
        step(12);

        // reset in the middle of a debounce
        key_n[2] = 1'b0;
        step(5);
        reset_reset = 1'b1;
        #1;
        chk_reset_vals("async");
        @(negedge clk_clk);
        reset_reset = 1'b0;
        model_reset();
        step(10); chk("press2_after_reset", key_press, 4'b0100);
        step(5);  chk("level2_after_reset", key_level, 4'b0100);
        key_n[2] = 1'b1;
        step(12);

        // randomized phase
        for (int i = 0; i < NK; i++) hold_left[i] = 0;
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NK; i++) begin
                if (hold_left[i] == 0) begin
                    key_n[i] = 1'($urandom_range(0, 1));
                    hold_left[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(8, 40))
                                                               : int'($urandom_range(1, 9));
                end else begin
                    hold_left[i]--;
                end
            end
            wifi_reset_n_in = ($urandom_range(0, 39) != 0);
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
